// File: rtl/ctrl_mc_fsm.sv
// Multi-cycle control unit: accepts one instruction via valid/ready and walks it
// through DECODE, EXEC, MEM and WB, driving datapath controls one state at a time.
module ctrl_mc_fsm #(
  parameter int OPW         = 5,
  parameter int AOPW        = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  // instr_valid/instr_ready: an instruction is taken on a rising edge where both
  // are high; instr_ready is high only in IDLE, so acceptance is never back-to-back.
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [1:0]      bc,
  input  logic            ct,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  input  logic            mem_ready,
  input  logic            clear_err,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            mem_reg,
  output logic            alu_src,
  output logic            sel_ex,
  output logic            branch,
  output logic            jump,
  output logic [1:0]      pc_nxt,
  output logic            pc_write,
  output logic [AOPW-1:0] alu_op,
  output logic            busy,
  output logic            illegal,
  output logic            timeout,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t         state_q, state_d;
  logic [1:0]     bc_q, bc_d;
  logic           ct_q, ct_d;
  logic [OPW-1:0] op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           illegal_q, illegal_d;
  logic           timeout_q, timeout_d;
  logic           trap_first_q, trap_first_d;

  logic           op_legal;
  logic           is_load;
  logic [4:0]     alu_tbl;
  logic [4:0]     alu_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bc_q         <= '0;
      ct_q         <= 1'b0;
      op_q         <= '0;
      cnt_q        <= '0;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
      trap_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bc_q         <= bc_d;
      ct_q         <= ct_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      illegal_q    <= illegal_d;
      timeout_q    <= timeout_d;
      trap_first_q <= trap_first_d;
    end
  end

  // ALU-class opcode to alu_op map; only meaningful for legal ALU opcodes.
  always_comb begin
    alu_tbl = 5'd0;
    if      (op_q <= OPW'(1))  alu_tbl = 5'd1;
    else if (op_q == OPW'(2))  alu_tbl = 5'd2;
    else if (op_q <= OPW'(4))  alu_tbl = 5'd3;
    else if (op_q <= OPW'(6))  alu_tbl = 5'd4;
    else if (op_q == OPW'(7))  alu_tbl = 5'd5;
    else if (op_q == OPW'(8))  alu_tbl = 5'd6;
    else if (op_q <= OPW'(12)) alu_tbl = op_q[4:0] - 5'd1;
    else                       alu_tbl = op_q[4:0] - 5'd2;
  end

  always_comb begin
    op_legal = 1'b0;
    case (bc_q)
      2'b00:   op_legal = (op_q != OPW'(13)) && (op_q <= OPW'(18));
      2'b01:   op_legal = (op_q <= OPW'(1));
      default: op_legal = (op_q == '0);
    endcase
  end

  assign is_load = (bc_q == 2'b01) && !op_q[0];

  always_comb begin
    state_d      = state_q;
    bc_d         = bc_q;
    ct_d         = ct_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    trap_first_d = 1'b0;
    instr_ready  = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_reg      = 1'b0;
    alu_src      = 1'b0;
    sel_ex       = 1'b0;
    branch       = 1'b0;
    jump         = 1'b0;
    pc_nxt       = 2'b00;
    pc_write     = 1'b0;
    alu_sel      = 5'd0;

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          bc_d    = bc;
          ct_d    = ct;
          op_d    = opcode;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_d    = 1'b1;
          trap_first_d = 1'b1;
          state_d      = S_TRAP;
        end
      end
      S_EXEC: begin
        case (bc_q)
          2'b00: begin
            alu_sel = alu_tbl;
            alu_src = ct_q;
            sel_ex  = ct_q;
            state_d = S_WB;
          end
          2'b01: begin
            alu_sel = 5'd1;
            alu_src = 1'b1;
            sel_ex  = 1'b1;
            cnt_d   = '0;
            state_d = S_MEM;
          end
          2'b10: begin
            alu_sel  = 5'd2;
            branch   = 1'b1;
            pc_write = 1'b1;
            pc_nxt   = zero ? 2'b01 : 2'b00;
            state_d  = S_IDLE;
          end
          default: begin
            jump     = 1'b1;
            pc_write = 1'b1;
            pc_nxt   = 2'b10;
            state_d  = S_IDLE;
          end
        endcase
      end
      S_MEM: begin
        // mem_ready wins over an expiring counter in the same cycle.
        if (mem_ready) begin
          mem_read  = is_load;
          mem_write = !is_load;
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_write = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (cnt_q == CW'(MEM_TIMEOUT)) begin
          timeout_d    = 1'b1;
          trap_first_d = 1'b1;
          state_d      = S_TRAP;
        end else begin
          mem_read  = is_load;
          mem_write = !is_load;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        mem_reg   = is_load;
        pc_write  = 1'b1;
        state_d   = S_IDLE;
      end
      S_TRAP: begin
        if (trap_first_q) begin
          pc_write = 1'b1;
          pc_nxt   = 2'b11;
        end
        if (clear_err) begin
          illegal_d = 1'b0;
          timeout_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign alu_op    = AOPW'(alu_sel);
  assign busy      = (state_q != S_IDLE);
  assign illegal   = illegal_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule
